// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider for unsigned operands: one quotient bit per clock,
// with a start/busy/done handshake and registered results.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] dq_w;
  logic [WIDTH-1:0] dvs_w;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dq_next;

  // Ripple full-adder chain computing shifted + ~{0,divisor} + 1; the top
  // stage only needs its carry since the result never exceeds WIDTH bits.
  always_comb begin
    shifted = {rem_w, dq_w[WIDTH-1]};
    diff    = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = shifted[i] ^ ~dvs_w[i] ^ carry;
      carry   = (shifted[i] & ~dvs_w[i]) | (carry & (shifted[i] ^ ~dvs_w[i]));
    end
    no_borrow = shifted[WIDTH] | carry;
    rem_next  = no_borrow ? diff : shifted[WIDTH-1:0];
    dq_next   = {dq_w[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_w       <= '0;
      dq_w        <= '0;
      dvs_w       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dq_w        <= dividend;
              dvs_w       <= divisor;
              rem_w       <= '0;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          rem_w <= rem_next;
          dq_w  <= dq_next;
          cnt   <= cnt - 1'b1;
          // Last iteration: publish the freshly computed bits, not the stale ones.
          if (cnt == CW'(1)) begin
            quotient  <= dq_next;
            remainder <= rem_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks for seq_restoring_divider at WIDTH=8 and WIDTH=4.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] dividend, divisor;
  logic       busy8, done8, dbz8;
  logic [7:0] q8, r8;
  logic       busy4, done4, dbz4;
  logic [3:0] q4, r4;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend), .divisor(divisor),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  seq_restoring_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dividend[3:0]), .divisor(divisor[3:0]),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  function automatic logic curBusy(input bit w4);
    return w4 ? busy4 : busy8;
  endfunction

  function automatic logic curDone(input bit w4);
    return w4 ? done4 : done8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present operands across one rising edge, then scramble them.
  task automatic applyStimulus(input bit w4, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start8   = !w4;
    start4   = w4;
    @(negedge clk);
    start8   = 1'b0;
    start4   = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic waitResult(input bit w4, input int startOff, output int off,
                            output int busyCnt, output int overlap);
    off     = startOff;
    busyCnt = startOff;
    overlap = 0;
    while (off < 40) begin
      if (curBusy(w4) && curDone(w4)) overlap++;
      if (curDone(w4)) break;
      if (curBusy(w4)) busyCnt++;
      off++;
      @(negedge clk);
    end
  endtask

  task automatic checkResult(input string tag, input bit w4, input logic [7:0] a,
                             input logic [7:0] b, input int startOff, input bit pokeDone);
    int w, off, busyCnt, overlap;
    logic [31:0] eq, er, ed, oq, orr;
    w = w4 ? 4 : 8;
    if (b == 8'd0) begin
      eq = w4 ? 32'd15 : 32'd255;
      er = 32'(a);
      ed = 1;
    end else begin
      eq = 32'(a / b);
      er = 32'(a % b);
      ed = 0;
    end
    waitResult(w4, startOff, off, busyCnt, overlap);
    oq  = w4 ? 32'(q4) : 32'(q8);
    orr = w4 ? 32'(r4) : 32'(r8);
    checkOutput($sformatf("%s_done_offset", tag), 32'(off), (b == 8'd0) ? 32'd0 : 32'(w));
    checkOutput($sformatf("%s_busy_cycles", tag), 32'(busyCnt), (b == 8'd0) ? 32'd0 : 32'(w));
    checkOutput($sformatf("%s_busy_done_overlap", tag), 32'(overlap), 32'd0);
    checkOutput($sformatf("%s_quotient", tag), oq, eq);
    checkOutput($sformatf("%s_remainder", tag), orr, er);
    checkOutput($sformatf("%s_div_by_zero", tag), w4 ? 32'(dbz4) : 32'(dbz8), ed);
    if (b != 8'd0) begin
      checkOutput($sformatf("%s_invariant", tag), oq * 32'(b) + orr, 32'(a));
      checkOutput($sformatf("%s_rem_lt_divisor", tag), 32'(orr < 32'(b)), 32'd1);
    end
    if (pokeDone) begin
      start8   = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd3;
    end
    @(negedge clk);
    start8 = 1'b0;
    checkOutput($sformatf("%s_done_one_cycle", tag), 32'(curDone(w4)), 32'd0);
    checkOutput($sformatf("%s_busy_after_done", tag), 32'(curBusy(w4)), 32'd0);
  endtask

  task automatic checkDivision(input string tag, input bit w4, input logic [7:0] a, input logic [7:0] b);
    applyStimulus(w4, a, b);
    checkResult(tag, w4, a, b, 0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start8   = 1'b0;
    start4   = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy8), 0);
    checkOutput("reset_done", 32'(done8), 0);
    checkOutput("reset_quotient", 32'(q8), 0);
    checkOutput("reset_remainder", 32'(r8), 0);
    checkOutput("reset_dbz", 32'(dbz8), 0);
    rst = 1'b0;

    checkDivision("d100_7", 0, 8'd100, 8'd7);
    checkDivision("d255_1", 0, 8'd255, 8'd1);
    checkDivision("d255_255", 0, 8'd255, 8'd255);
    checkDivision("d5_9", 0, 8'd5, 8'd9);
    checkDivision("d0_3", 0, 8'd0, 8'd3);

    checkDivision("d77_0", 0, 8'd77, 8'd0);
    applyStimulus(0, 8'd9, 8'd3);
    checkOutput("dbz_cleared_on_accept", 32'(dbz8), 0);
    checkOutput("quotient_held_on_accept", 32'(q8), 255);
    checkOutput("remainder_held_on_accept", 32'(r8), 77);
    checkResult("d9_3", 0, 8'd9, 8'd3, 0, 1'b0);

    // Extra starts during RUN and DONE must not disturb 100/7.
    applyStimulus(0, 8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    start8   = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    checkResult("ignore_start", 0, 8'd100, 8'd7, 3, 1'b1);
    @(negedge clk);
    checkOutput("ignore_start_not_accepted", 32'(busy8), 0);
    checkOutput("ignore_start_quotient", 32'(q8), 14);
    checkOutput("ignore_start_remainder", 32'(r8), 2);

    // Reset three cycles into RUN.
    applyStimulus(0, 8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_rst_busy", 32'(busy8), 0);
    checkOutput("midrun_rst_done", 32'(done8), 0);
    checkOutput("midrun_rst_quotient", 32'(q8), 0);
    checkOutput("midrun_rst_remainder", 32'(r8), 0);
    checkOutput("midrun_rst_dbz", 32'(dbz8), 0);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    checkOutput("midrun_rst_no_done", 32'(pulses), 0);
    checkDivision("d200_13", 0, 8'd200, 8'd13);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst      = 1'b1;
    start8   = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd2;
    @(negedge clk);
    rst    = 1'b0;
    start8 = 1'b0;
    checkOutput("rst_start_busy", 32'(busy8), 0);
    @(negedge clk);
    checkOutput("rst_start_not_accepted", 32'(busy8), 0);
    checkOutput("rst_start_done", 32'(done8), 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        checkDivision("w4_sweep", 1, 8'(a), 8'(b));

    for (int n = 0; n < 3000; n++)
      checkDivision("w8_rand", 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
